// File: rtl/mem_access_pkg.sv
// Shared types and op codes for the MEM stage.
// Includes the write-back record, ALU op bundle and FSM state encoding.
package mem_access_pkg;

  typedef logic [31:0] ram_addr_t;
  typedef logic [3:0]  ram_be_t;
  typedef logic [1:0]  mem_state_t;

  localparam mem_state_t S_IDLE = 2'd0;
  localparam mem_state_t S_WAIT = 2'd1;
  localparam mem_state_t S_DONE = 2'd2;

  localparam logic [7:0] OR_OP = 8'h25;
  localparam logic [7:0] LB_OP = 8'h20;
  localparam logic [7:0] LW_OP = 8'h23;
  localparam logic [7:0] SB_OP = 8'h28;
  localparam logic [7:0] SW_OP = 8'h2B;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } reg_t;

  typedef struct packed {
    logic [7:0] op;
    logic [2:0] sel;
  } alu_t;

endpackage

// File: rtl/mem_access_if.sv
// Data-RAM req/ack port between the MEM stage and the RAM.
// The master issues requests; the slave answers with a one-cycle ack.
interface mem_access_if
  import mem_access_pkg::*;
();

  logic        req;
  logic        we;
  ram_be_t     be;
  ram_addr_t   addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, be, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for LB/LW/SB/SW.
// Produces byte enables, replicated store data, load result and misalign flag.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  i_op,
  input  logic [1:0]  i_a,
  input  logic [31:0] i_stdata,
  input  logic [31:0] i_rdata,
  output ram_be_t     o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata,
  output logic        o_misalign,
  output logic        o_is_mem,
  output logic        o_is_load,
  output logic        o_is_store
);

  logic       w_lb;
  logic       w_lw;
  logic       w_sb;
  logic       w_sw;
  logic [7:0] w_byte;

  assign w_lb = (i_op == LB_OP);
  assign w_lw = (i_op == LW_OP);
  assign w_sb = (i_op == SB_OP);
  assign w_sw = (i_op == SW_OP);

  assign o_is_load  = w_lb | w_lw;
  assign o_is_store = w_sb | w_sw;
  assign o_is_mem   = o_is_load | o_is_store;

  assign w_byte = i_rdata[{i_a, 3'b000} +: 8];

  always_comb begin
    o_be       = '0;
    o_wdata    = '0;
    o_ldata    = i_rdata;
    o_misalign = 1'b0;
    unique case (1'b1)
      w_lb: begin
        o_be    = 4'b0001 << i_a;
        o_ldata = {{24{w_byte[7]}}, w_byte};
      end
      w_lw: begin
        o_be       = 4'hF;
        o_misalign = |i_a;
      end
      w_sb: begin
        o_be    = 4'b0001 << i_a;
        o_wdata = {4{i_stdata[7:0]}};
      end
      w_sw: begin
        o_be       = 4'hF;
        o_wdata    = i_stdata;
        o_misalign = |i_a;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: runs data-RAM transactions, stalls while open,
// and registers the write-back record for WB.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  reg_t         mem_wreg_i,
  input  alu_t         mem_alu_i,
  input  ram_addr_t    mem_ramaddr_i,
  input  logic [31:0]  mem_stdata_i,
  output reg_t         mem_wreg_o,
  output logic         mem_err_o,
  output logic         mem_stallreq,
  mem_access_if.master ram
);

  mem_state_t  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_req;
  logic        r_we;
  ram_be_t     r_be;
  ram_addr_t   r_addr;
  logic [31:0] r_wdata;

  ram_be_t     w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;
  logic        w_misalign;
  logic        w_is_mem;
  logic        w_is_load;
  logic        w_is_store;
  reg_t        w_wb;
  logic        w_unused;

  assign w_unused = ^mem_alu_i.sel;

  mem_lane_align u_align (
    .i_op       (mem_alu_i.op),
    .i_a        (mem_ramaddr_i[1:0]),
    .i_stdata   (mem_stdata_i),
    .i_rdata    (r_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata),
    .o_misalign (w_misalign),
    .o_is_mem   (w_is_mem),
    .o_is_load  (w_is_load),
    .o_is_store (w_is_store)
  );

  assign mem_stallreq = w_is_mem && (r_state != S_DONE);

  assign ram.req   = r_req;
  assign ram.we    = r_we;
  assign ram.be    = r_be;
  assign ram.addr  = r_addr;
  assign ram.wdata = r_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mem && w_misalign) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
          end else if (w_is_mem) begin
            r_state <= S_WAIT;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_we    <= w_is_store;
            r_be    <= w_be;
            r_addr  <= {mem_ramaddr_i[31:2], 2'b00};
            r_wdata <= w_wdata;
          end
        end
        S_WAIT: begin
          // ack wins over a coinciding timeout
          if (ram.ack) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_rdata <= ram.rdata;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wb = mem_wreg_i;
    if (w_is_load) w_wb.data = w_ldata;
    if (w_is_store || r_err) w_wb.en = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wreg_o <= '0;
      mem_err_o  <= 1'b0;
    end else if (!mem_stallreq) begin
      mem_wreg_o <= w_wb;
      mem_err_o  <= w_is_mem && r_err;
    end else begin
      mem_wreg_o.en <= 1'b0;
      mem_err_o     <= 1'b0;
    end
  end

endmodule
